// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding common to initiator and target,
// address width and acknowledge levels.
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ADDR   = 4'd2,
        ST_ACK0   = 4'd3,
        ST_W_DATA = 4'd4,
        ST_ACK1   = 4'd5,
        ST_R_DATA = 4'd6,
        ST_ACK2   = 4'd7,
        ST_STOP   = 4'd8,
        ST_IGNORE = 4'd9
    } state_t;

    // Target-side names for the shared encodings.
    localparam state_t ST_ADDR_ACK  = ST_ACK0;
    localparam state_t ST_WRITE     = ST_W_DATA;
    localparam state_t ST_WRITE_ACK = ST_ACK1;
    localparam state_t ST_READ      = ST_R_DATA;
    localparam state_t ST_READ_ACK  = ST_ACK2;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from one history register.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    // Preset to the idle bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda     = r_sda_sync[SYNC_STAGES-1];
    assign sda_lvl   = w_sda;
    assign scl_rise  =  w_scl & ~r_scl_hist;
    assign scl_fall  = ~w_scl &  r_scl_hist;
    assign start_det = w_scl & r_scl_hist &  r_sda_hist & ~w_sda;
    assign stop_det  = w_scl & r_scl_hist & ~r_sda_hist &  w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: matches OWN_ADDR, delivers written bytes on rx_data and
// shifts out tx_data on reads. All handshakes are single-clk pulses.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int                ADDR_W      = 7,
    parameter logic [ADDR_W-1:0] OWN_ADDR    = 7'h42,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy,
    output logic [3:0] dbg_state
);

    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    state_t     r_state;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_rd_ack;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_lvl   (w_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    assign w_byte    = {r_shift[6:0], w_sda};
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_rd_ack <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            addr_hit <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= 3'd0;
                r_rd_ack <= 1'b0;
                busy     <= 1'b1;
                addr_hit <= 1'b0;
                sda_oe   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                busy     <= 1'b0;
                addr_hit <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                rw      <= w_sda;
                                r_state <= (w_byte[7:1] == OWN_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                            end
                        end
                    end
                    // First fall starts the ACK clock, the second one ends it.
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe   <= 1'b1;
                                addr_hit <= 1'b1;
                                tx_req   <= rw;
                            end else if (rw) begin
                                r_shift  <= tx_data;
                                sda_oe   <= ~tx_data[7];
                                r_bitcnt <= 3'd0;
                                r_state  <= ST_READ;
                            end else begin
                                sda_oe   <= 1'b0;
                                r_bitcnt <= 3'd0;
                                r_state  <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                rx_data  <= w_byte;
                                rx_valid <= 1'b1;
                            end
                        end else if (w_scl_fall && r_bitcnt == 3'd0) begin
                            sda_oe  <= 1'b1;
                            r_state <= ST_WRITE_ACK;
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe   <= 1'b0;
                            r_bitcnt <= 3'd0;
                            r_state  <= ST_WRITE;
                        end
                    end
                    // Counter wrapped to 0 on a fall means all 8 bits went out.
                    ST_READ: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 3'd0) begin
                                sda_oe   <= 1'b0;
                                r_rd_ack <= 1'b0;
                                r_state  <= ST_READ_ACK;
                            end else begin
                                sda_oe <= ~r_shift[3'd7 - r_bitcnt];
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == ACK) begin
                                tx_req   <= 1'b1;
                                r_rd_ack <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end else if (w_scl_fall && r_rd_ack) begin
                            r_shift  <= tx_data;
                            sda_oe   <= ~tx_data[7];
                            r_bitcnt <= 3'd0;
                            r_rd_ack <= 1'b0;
                            r_state  <= ST_READ;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: drives the bus as an initiator and scoreboards
// written bytes, read-back bytes and tx_req pulses.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv;
    logic       sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addr_hit;
    logic       rw;
    logic       busy;
    logic [3:0] dbg_state;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int tx_req_cnt = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] tx_src_q[$];

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_drv),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .addr_hit  (addr_hit),
        .rw        (rw),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                rx_cnt++;
                if (rx_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
                end
            end
        end
    end

    // Local-logic model: present the next queued byte when asked.
    initial begin
        tx_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (tx_req) begin
                tx_req_cnt++;
                if (tx_src_q.size() > 0) tx_data = tx_src_q.pop_front();
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b, output logic oe_seen);
        sda_drv = b; wait_q();
        scl_drv = 1'b1; wait_q();
        oe_seen = sda_oe;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b, output logic oe_seen);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        b = sda_bus;
        oe_seen = sda_oe;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic oe;
        logic oe_any;
        logic bit_v;
        oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], oe);
            oe_any |= oe;
        end
        check({tag, "_data_oe"}, {31'd0, oe_any}, 32'd0);
        recv_bit(bit_v, oe);
        check({tag, "_ack_oe"}, {31'd0, oe}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic ack_bit, input string tag);
        logic [7:0] got;
        logic       b;
        logic       oe;
        got = 8'd0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b, oe);
            got = {got[6:0], b};
        end
        send_bit(ack_bit, oe);
        check({tag, "_ack_release"}, {31'd0, oe}, 32'd0);
        check({tag, "_byte"}, {24'd0, got}, {24'd0, rd_exp_q.pop_front()});
    endtask

    initial begin
        int snap;
        logic b;
        logic oe;
        rst = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, ST_IDLE);
        rst = 1'b1;
        wait_q();

        // 1: write A5, 3C to own address
        i2c_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_state", {28'd0, dbg_state}, ST_ADDR);
        send_byte({7'h42, 1'b0}, 1'b1, "t1_addr");
        check("t1_addr_hit", {31'd0, addr_hit}, 32'd1);
        rx_exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, "t1_b1");
        rx_exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, "t1_b2");
        i2c_stop();
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_hit_after_stop", {31'd0, addr_hit}, 32'd0);
        check("t1_state_idle", {28'd0, dbg_state}, ST_IDLE);
        check("t1_rx_cnt", rx_cnt, 32'd2);

        // 2: address mismatch
        snap = rx_cnt;
        i2c_start();
        send_byte({7'h17, 1'b0}, 1'b0, "t2_addr");
        check("t2_addr_hit", {31'd0, addr_hit}, 32'd0);
        check("t2_state", {28'd0, dbg_state}, ST_IGNORE);
        send_byte(8'h55, 1'b0, "t2_data");
        check("t2_state_hold", {28'd0, dbg_state}, ST_IGNORE);
        i2c_stop();
        check("t2_state_idle", {28'd0, dbg_state}, ST_IDLE);
        check("t2_rx_cnt", rx_cnt, snap);

        // 3: read C3 (ACK) then 5A (NACK)
        snap = tx_req_cnt;
        tx_src_q.push_back(8'hC3);
        tx_src_q.push_back(8'h5A);
        rd_exp_q.push_back(8'hC3);
        rd_exp_q.push_back(8'h5A);
        i2c_start();
        send_byte({7'h42, 1'b1}, 1'b1, "t3_addr");
        check("t3_rw", {31'd0, rw}, 32'd1);
        check("t3_addr_hit", {31'd0, addr_hit}, 32'd1);
        read_byte(ACK, "t3_b1");
        read_byte(NACK, "t3_b2");
        check("t3_sda_oe_nack", {31'd0, sda_oe}, 32'd0);
        check("t3_state_ignore", {28'd0, dbg_state}, ST_IGNORE);
        check("t3_tx_req_cnt", tx_req_cnt - snap, 32'd2);
        i2c_stop();

        // 4: write then repeated START into a read
        i2c_start();
        send_byte({7'h42, 1'b0}, 1'b1, "t4_waddr");
        rx_exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, "t4_wb");
        check("t4_rw_write", {31'd0, rw}, 32'd0);
        i2c_start();
        check("t4_busy_rs", {31'd0, busy}, 32'd1);
        check("t4_hit_cleared", {31'd0, addr_hit}, 32'd0);
        check("t4_state_rs", {28'd0, dbg_state}, ST_ADDR);
        tx_src_q.push_back(8'h96);
        rd_exp_q.push_back(8'h96);
        send_byte({7'h42, 1'b1}, 1'b1, "t4_raddr");
        check("t4_rw_read", {31'd0, rw}, 32'd1);
        check("t4_hit_again", {31'd0, addr_hit}, 32'd1);
        check("t4_busy_read", {31'd0, busy}, 32'd1);
        read_byte(NACK, "t4_rb");
        i2c_stop();

        // 5: async reset mid read byte, then a clean write
        tx_src_q.push_back(8'hE1);
        i2c_start();
        send_byte({7'h42, 1'b1}, 1'b1, "t5_addr");
        for (int i = 0; i < 4; i++) recv_bit(b, oe);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_addr_hit", {31'd0, addr_hit}, 32'd0);
        check("t5_rst_rw", {31'd0, rw}, 32'd0);
        check("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("t5_rst_state", {28'd0, dbg_state}, ST_IDLE);
        wait_q();
        rst = 1'b1;
        sda_drv = 1'b1;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        snap = rx_cnt;
        i2c_start();
        send_byte({7'h42, 1'b0}, 1'b1, "t5_waddr");
        rx_exp_q.push_back(8'h77);
        send_byte(8'h77, 1'b1, "t5_wb");
        i2c_stop();
        check("t5_rx_cnt", rx_cnt - snap, 32'd1);
        check("t5_busy_end", {31'd0, busy}, 32'd0);

        // 6: STOP after 4 bits of a write byte
        snap = rx_cnt;
        i2c_start();
        send_byte({7'h42, 1'b0}, 1'b1, "t6_addr");
        for (int i = 0; i < 4; i++) send_bit(1'b1, oe);
        i2c_stop();
        check("t6_state", {28'd0, dbg_state}, ST_IDLE);
        check("t6_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_rx_cnt", rx_cnt, snap);

        wait_q();
        check("rx_queue_empty", rx_exp_q.size(), 32'd0);
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the team's I2C initiator. The initiator drives open-drain SDA/SCL with a 7-bit address, an R/W bit, data bytes and per-byte ACKs.
- This block oversamples SCL/SDA on the system clock, detects START/STOP, matches its own address and ACKs it.
- On writes, it delivers received bytes to local logic. On reads, it shifts out bytes supplied by local logic.
- It sits on the peripheral side of the bus, opposite the initiator.

Parameters:
- ADDR_W, 7, address width (fixed 7-bit I2C addressing)
- OWN_ADDR, 7'h42, target address this block responds to
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2)

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate
- rst  input  1  asynchronous active-low reset
- scl_i  input  1  bus SCL level (asynchronous)
- sda_i  input  1  bus SDA level (asynchronous)
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- rx_data  output  8  last byte written by the initiator
- rx_valid  output  1  one-clk pulse; rx_data is new
- tx_data  input  8  byte to return on a read
- tx_req  output  1  one-clk pulse; local logic must present the next tx_data
- addr_hit  output  1  high from address ACK until STOP or repeated START
- rw  output  1  R/W bit of the current transaction (1 = read)
- busy  output  1  high between a START and the following STOP

Behaviour:
- Reset (rst=0, async):
  - sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, addr_hit=0, rw=0, busy=0.
  - State IDLE; synchronizers preset to 1.
- Input path:
  - SYNC_STAGES-flop synchronizer, then one history register.
  - Edge/condition detection latency is SYNC_STAGES+1 clks after a pin change.
- Bus conditions, evaluated every clk on synchronized values:
  - START = SDA 1->0 while SCL high.
  - STOP = SDA 0->1 while SCL high.
  - Both take priority over the bit FSM.
- START in any state (repeated START included):
  - State ADDR, bit count 0, busy=1, addr_hit=0, sda_oe=0.
- STOP in any state:
  - State IDLE, busy=0, addr_hit=0, sda_oe=0.
- Data sampling and driving:
  - Data is sampled on the synchronized SCL rising edge, MSB first.
  - sda_oe changes only on the synchronized SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- ADDR:
  - Shift 8 bits.
  - On the 8th rising edge, compare bits[7:1] with OWN_ADDR and latch rw = bit0.
  - Match -> ADDR_ACK: sda_oe=1 at the next SCL fall. If rw=1, tx_req pulses in the same clk as that SCL fall.
  - Mismatch -> IGNORE: sda_oe stays 0.
- ADDR_ACK:
  - addr_hit=1.
  - At the SCL fall ending the ACK clock, go to WRITE (sda_oe=0) or READ.
  - For READ: load tx_data into the shift register and drive sda_oe = ~tx_data[7] in that clk.
- WRITE:
  - 8 rising edges.
  - On the 8th, rx_data <= shifted byte and rx_valid pulses 1 clk.
  - Next SCL fall: WRITE_ACK, sda_oe=1 (always ACK).
  - SCL fall after the ACK clock: sda_oe=0, back to WRITE.
- READ:
  - After each SCL fall, sda_oe = ~shift[7-bitcnt].
  - After the 8th bit's SCL fall, release sda_oe and go to READ_ACK.
- READ_ACK:
  - Sample SDA on the SCL rise.
  - 0 (ACK): tx_req pulses at that rise; tx_data is loaded at the next SCL fall; continue READ.
  - 1 (NACK): IGNORE with sda_oe=0.
- IGNORE: sda_oe=0; wait for STOP or START.
- tx_data contract:
  - Must be stable from tx_req + 2 clks through the SCL fall where it is loaded.
  - No flow control or clock stretching.
- Bit counter: 3 bits, wraps 7->0 on a byte boundary.
- Glitches:
  - SDA change while SCL high inside a byte = START/STOP (protocol rule).
  - No additional filtering.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants, shared with the initiator: IDLE, START, ADDR, ACK0, W_DATA, ACK1, R_DATA, ACK2, STOP plus the target-only states above;
  - ADDR_W;
  - the ACK=0 / NACK=1 constants.
- One sub-module, i2c_sync_edge: synchronizer plus history register. It outputs scl_rise, scl_fall, start_det, stop_det and sync levels. It is instantiated once.

Test Plan:
1. Write to 7'h42, then bytes 8'hA5, 8'h3C, then STOP:
   - sda_oe=1 during the ACK clock of the address and of each byte;
   - rx_valid pulses twice with rx_data A5 then 3C;
   - busy falls after STOP.
2. Write to 7'h17 (mismatch):
   - no ACK (sda_oe=0 throughout), no rx_valid, addr_hit=0;
   - FSM in IGNORE until STOP.
3. Read from 7'h42 with tx_data=8'hC3, then 8'h5A; initiator ACKs byte 1 and NACKs byte 2:
   - bus shows C3 then 5A;
   - tx_req pulses twice;
   - sda_oe=0 after the NACK.
4. Repeated START after a write byte, then a read from 7'h42:
   - rw goes 0->1 and addr_hit is re-asserted;
   - no STOP in between; busy stays 1.
5. Assert rst low mid-byte during READ, release, then send a new START:
   - all outputs return to reset values immediately (async);
   - the next transaction completes normally.
6. STOP in the middle of a write byte (after 4 bits):
   - IDLE, no rx_valid, sda_oe=0.
